// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: SRAM geometry, access FSM states and the
// EX/MEM pipeline register payload.
package mem_stage_pkg;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   val_rm;
    logic [REG_AW-1:0] dest;
  } exmem_t;

endpackage

// File: rtl/sram_access_fsm.sv
// Sequences one 32-bit load/store as two fixed-latency half-word SRAM
// accesses (low half first) and assembles load data.
// Ports: clk, rst (sync, active-high); r_en/w_en/alu_res/val_rm from the
// EX/MEM register; sram_* pins; ready_c (combinational stall release),
// done (DONE state), rdata (assembled load data).
module sram_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r_en,
  input  logic               w_en,
  input  logic [XLEN-1:0]    alu_res,
  input  logic [XLEN-1:0]    val_rm,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               ready_c,
  output logic               done,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  output logic               sram_we_n,
  output logic [XLEN-1:0]    rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       state;
  mem_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             mem_op;
  logic             is_load;
  logic [XLEN-1:0]  offset;
  logic [16:0]      word;
  logic             access_nxt;
  logic             half_nxt;
  logic             unused_offset;

  assign mem_op   = r_en | w_en;
  // Both enables set is a store, so only a pure read captures data.
  assign is_load  = r_en & ~w_en;
  assign cnt_last = (cnt == CNT_LAST);

  // Modulo-2^32 rebase; underflow simply wraps.
  assign offset        = alu_res - XLEN'(BASE_ADDR);
  assign word          = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  assign ready_c = ((state == IDLE) && !mem_op) || (state == DONE);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_op)   state_nxt = LO;
      LO:   if (cnt_last) state_nxt = HI;
      HI:   if (cnt_last) state_nxt = DONE;
      DONE:               state_nxt = IDLE;
    endcase
  end

  // Wait counter: runs inside LO/HI, cleared on every phase boundary.
  always_ff @(posedge clk) begin
    if (rst || cnt_last || (state == IDLE) || (state == DONE)) cnt <= '0;
    else                                                       cnt <= cnt + CNT_W'(1);
  end

  assign access_nxt = (state_nxt == LO) || (state_nxt == HI);
  assign half_nxt   = (state_nxt == HI);

  // Pins are registered from the next state so they line up with LO/HI.
  always_ff @(posedge clk) begin
    if (rst || !access_nxt) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
    end else begin
      sram_addr  <= {word, half_nxt};
      sram_wdata <= !w_en   ? '0 :
                    half_nxt ? val_rm[31:16] : val_rm[15:0];
      sram_we_n  <= ~w_en;
    end
  end

  // Load data captured on the last cycle of each half access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (is_load && cnt_last) begin
      if (state == LO)      rdata[15:0]  <= sram_rdata;
      else if (state == HI) rdata[31:16] <= sram_rdata;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: EX/MEM register plus a two-half-word SRAM sequencer.
// ready=0 freezes the front of the pipeline while an access is in flight.
// Ports: clk, rst (sync, active-high); exe_* from EX; mem_* to WB and
// forwarding; sram_* to the 16-bit SRAM.
// Optional: MEM_STAGE_STATS_EN adds stat_stall_cycles and stat_mem_ops.
module mem_stage_sram
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exe_wb_en,
  input  logic               exe_mem_r_en,
  input  logic               exe_mem_w_en,
  input  logic [XLEN-1:0]    exe_alu_res,
  input  logic [XLEN-1:0]    exe_val_rm,
  input  logic [REG_AW-1:0]  exe_dest,
  output logic               mem_wb_en,
  output logic               mem_mem_r_en,
  output logic [REG_AW-1:0]  mem_dest,
  output logic [XLEN-1:0]    mem_alu_res,
  output logic [XLEN-1:0]    mem_rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n
`ifdef MEM_STAGE_STATS_EN
  ,
  output logic [31:0]        stat_stall_cycles,
  output logic [31:0]        stat_mem_ops
`endif
);

  exmem_t exe_d;
  exmem_t mem_q;
  logic   ready_c;
  logic   done;

  always_comb begin
    exe_d          = '0;
    exe_d.wb_en    = exe_wb_en;
    exe_d.mem_r_en = exe_mem_r_en;
    exe_d.mem_w_en = exe_mem_w_en;
    exe_d.alu_res  = exe_alu_res;
    exe_d.val_rm   = exe_val_rm;
    exe_d.dest     = exe_dest;
  end

  // EX/MEM register, frozen while the access is in flight.
  always_ff @(posedge clk) begin
    if (rst)          mem_q <= '0;
    else if (ready_c) mem_q <= exe_d;
  end

  assign mem_wb_en    = mem_q.wb_en;
  assign mem_mem_r_en = mem_q.mem_r_en;
  assign mem_dest     = mem_q.dest;
  assign mem_alu_res  = mem_q.alu_res;
  assign ready        = ready_c;

  sram_access_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BASE_ADDR   (BASE_ADDR)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .r_en       (mem_q.mem_r_en),
    .w_en       (mem_q.mem_w_en),
    .alu_res    (mem_q.alu_res),
    .val_rm     (mem_q.val_rm),
    .sram_rdata (sram_rdata),
    .ready_c    (ready_c),
    .done       (done),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we_n  (sram_we_n),
    .rdata      (mem_rdata)
  );

`ifdef MEM_STAGE_STATS_EN
  // Stall and completed-access counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_mem_ops      <= '0;
    end else begin
      if (!ready_c) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (done)     stat_mem_ops      <= stat_mem_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: each issued instruction pushes its
// expected per-cycle pin/register trace and expected load data; a negedge
// monitor pops and compares.
module tb_mem_stage_sram;

  localparam int unsigned WC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en;
  logic [31:0] exe_alu_res, exe_val_rm;
  logic [3:0]  exe_dest;
  logic        mem_wb_en, mem_mem_r_en;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_res, mem_rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n;
`ifdef MEM_STAGE_STATS_EN
  logic [31:0] stat_stall_cycles, stat_mem_ops;
`endif

  mem_stage_sram #(.WAIT_CYCLES(WC), .BASE_ADDR(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_mem_w_en (exe_mem_w_en),
    .exe_alu_res  (exe_alu_res),
    .exe_val_rm   (exe_val_rm),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_mem_r_en (mem_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_alu_res  (mem_alu_res),
    .mem_rdata    (mem_rdata),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_we_n    (sram_we_n)
`ifdef MEM_STAGE_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_mem_ops      (stat_mem_ops)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        we_n;
    logic [3:0]  dest;
    logic        wb_en;
    logic        r_en;
    logic [31:0] alu;
  } exp_t;

  exp_t        pin_q[$];
  logic [31:0] rd_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          stall_cnt = 0;
  exp_t        e;
  logic [31:0] er;

  // SRAM model: combinational read, writes on the clock edge.
  logic [15:0] sram_mem [0:63];
  assign sram_rdata = sram_mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= 16'h0000;
      sram_mem[0] <= 16'h1111;
      sram_mem[1] <= 16'h2222;
      sram_mem[2] <= 16'hBEEF;
      sram_mem[3] <= 16'hDEAD;
      sram_mem[4] <= 16'h5678;
      sram_mem[5] <= 16'h1234;
      sram_mem[6] <= 16'hCAFE;
      sram_mem[7] <= 16'hF00D;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr[5:0]] <= sram_wdata;
    end
  end

  // Monitor: per-cycle trace and load data whenever a load completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (!ready) stall_cnt++;
      if (pin_q.size() > 0) begin
        e = pin_q.pop_front();
        checks++;
        if (ready !== e.ready || sram_addr !== e.addr || sram_wdata !== e.wdata ||
            sram_we_n !== e.we_n || mem_dest !== e.dest || mem_wb_en !== e.wb_en ||
            mem_mem_r_en !== e.r_en || mem_alu_res !== e.alu) begin
          failures++;
          $display("FAIL trace t=%0t got rdy=%b addr=%h wd=%h we_n=%b dest=%h wb=%b r=%b alu=%h exp rdy=%b addr=%h wd=%h we_n=%b dest=%h wb=%b r=%b alu=%h",
                   $time, ready, sram_addr, sram_wdata, sram_we_n, mem_dest, mem_wb_en,
                   mem_mem_r_en, mem_alu_res, e.ready, e.addr, e.wdata, e.we_n, e.dest,
                   e.wb_en, e.r_en, e.alu);
        end
      end
      if (ready && mem_mem_r_en) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rdata_unexpected t=%0t got=%h exp=none", $time, mem_rdata);
        end else begin
          er = rd_q.pop_front();
          if (mem_rdata !== er) begin
            failures++;
            $display("FAIL rdata t=%0t got=%h exp=%h", $time, mem_rdata, er);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic [17:0] a, input logic [15:0] wd,
                              input logic we_n, input logic [3:0] d, input logic wb,
                              input logic r, input logic [31:0] alu);
    exp_t x;
    x.ready = rdy; x.addr = a; x.wdata = wd; x.we_n = we_n;
    x.dest = d; x.wb_en = wb; x.r_en = r; x.alu = alu;
    return x;
  endfunction

  // Present one instruction, wait for the stage to accept it, then push the
  // expected trace (lo_addr and exp_rd are hand-computed by the caller).
  task automatic issue(input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] val,
                       input logic [3:0] dest, input logic [17:0] lo_addr,
                       input logic [31:0] exp_rd);
    int n;
    @(negedge clk);
    exe_wb_en = wb; exe_mem_r_en = r; exe_mem_w_en = w;
    exe_alu_res = alu; exe_val_rm = val; exe_dest = dest;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ready) begin
      failures++;
      $display("FAIL accept_timeout got=stalled exp=ready dest=%h", dest);
    end
    @(posedge clk);
    if (r || w) begin
      pin_q.push_back(mk(1'b0, 18'd0, 16'h0, 1'b1, dest, wb, r, alu));
      for (int i = 0; i < WC; i++)
        pin_q.push_back(mk(1'b0, lo_addr, w ? val[15:0] : 16'h0, ~w, dest, wb, r, alu));
      for (int i = 0; i < WC; i++)
        pin_q.push_back(mk(1'b0, lo_addr + 18'd1, w ? val[31:16] : 16'h0, ~w, dest, wb, r, alu));
      pin_q.push_back(mk(1'b1, 18'd0, 16'h0, 1'b1, dest, wb, r, alu));
      if (r) rd_q.push_back(exp_rd);
    end else begin
      pin_q.push_back(mk(1'b1, 18'd0, 16'h0, 1'b1, dest, wb, r, alu));
    end
    #1;
    exe_wb_en = 0; exe_mem_r_en = 0; exe_mem_w_en = 0;
    exe_alu_res = 0; exe_val_rm = 0; exe_dest = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    rst = 1'b1;
    exe_wb_en = 0; exe_mem_r_en = 0; exe_mem_w_en = 0;
    exe_alu_res = 0; exe_val_rm = 0; exe_dest = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("reset_wdata", 32'(sram_wdata), 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    chk("reset_ctrl", {26'd0, mem_wb_en, mem_mem_r_en, mem_dest}, 32'd0);
`ifdef MEM_STAGE_STATS_EN
    chk("reset_stats", stat_stall_cycles | stat_mem_ops, 32'd0);
`endif
    rst = 1'b0;

    // Store 0xDEADBEEF to 1028 (half-words 2,3), then an ALU op.
    issue(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0, 18'd2, 32'd0);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 4'd5, 18'd0, 32'd0);
`ifdef MEM_STAGE_STATS_EN
    @(negedge clk);
    chk("stat_stall_cycles", stat_stall_cycles, 32'd7);
    chk("stat_mem_ops", stat_mem_ops, 32'd1);
`endif

    // Load back from 1028; ALU op dest=5 waits at the inputs during the load.
    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd7, 18'd2, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'd0, 4'd5, 18'd0, 32'd0);

    // Back-to-back loads from 1032 and 1036.
    s0 = stall_cnt;
    issue(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd8, 18'd4, 32'h12345678);
    issue(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd9, 18'd6, 32'hF00DCAFE);
    issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 18'd0, 32'd0);
    chk("b2b_stall_cycles", 32'(stall_cnt - s0), 32'd14);

    // Read+write together acts as a store; load data must not change.
    issue(1'b0, 1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, 4'd3, 18'd8, 32'hF00DCAFE);
    issue(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd4, 18'd8, 32'hA5A55A5A);

    // Address below BASE_ADDR wraps: 0-1024 -> word 0x1FF00 -> addr 0x3FE00.
    issue(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 4'd6, 18'h3FE00, 32'h22221111);
    issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 18'd0, 32'd0);

    n = 0;
    while (pin_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("trace_drained", 32'(pin_q.size()), 32'd0);
    chk("rdata_drained", 32'(rd_q.size()), 32'd0);

    // Reset during the high half of a store.
    @(negedge clk);
    exe_mem_w_en = 1'b1; exe_alu_res = 32'd1028; exe_val_rm = 32'h01020304;
    exe_dest = 4'd2; exe_wb_en = 1'b1;
    @(posedge clk);
    #1;
    exe_wb_en = 0; exe_mem_w_en = 0; exe_alu_res = 0; exe_val_rm = 0; exe_dest = 0;
    repeat (5) @(negedge clk);
    chk("mid_store_hi_addr", 32'(sram_addr), 32'd3);
    chk("mid_store_hi_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_mid_addr", 32'(sram_addr), 32'd0);
    chk("rst_mid_ctrl", {26'd0, mem_wb_en, mem_mem_r_en, mem_dest}, 32'd0);
    chk("rst_mid_alu", mem_alu_res, 32'd0);
    chk("rst_mid_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the five-stage pipeline: holds the EX/MEM pipeline register and sequences 32-bit loads and stores onto a 16-bit, fixed-latency SRAM as two half-word accesses. It drives the MEM-side destination and write-enable that the forwarding logic compares against. It also stalls the whole pipeline through `ready` while an access is in flight.

## Interface
- `WAIT_CYCLES`, default 3: cycles each half-word access is held on the SRAM pins; legal range 1..15.
- `BASE_ADDR`, default 1024: byte address subtracted from the ALU result before SRAM mapping.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exe_wb_en`, `exe_mem_r_en`, `exe_mem_w_en`  in  1 each  controls from EX.
- `exe_alu_res`  in  32  ALU result, used as the byte address for memory ops.
- `exe_val_rm`  in  32  store data.
- `exe_dest`  in  4  destination register.
- `mem_wb_en`, `mem_mem_r_en`  out  1 each  registered controls, passed to WB and forwarding.
- `mem_dest`  out  4  registered destination, passed to forwarding.
- `mem_alu_res`  out  32  registered ALU result; this is the forwarded value.
- `mem_rdata`  out  32  assembled load data.
- `ready`  out  1  0 means freeze PC, IF/ID, ID/EX and this register.
- `sram_addr`  out  18  half-word address.
- `sram_wdata`  out  16  write data.
- `sram_rdata`  in  16  read data.
- `sram_we_n`  out  1  active-low write strobe.

## Operation
- **EX/MEM register.**
  - On each edge with `ready`=1, load all `exe_*` inputs.
  - With `ready`=0, hold all fields.
  - `rst` clears every field to 0.
- **FSM states:** IDLE, LO, HI, DONE. A 4-bit wait counter `cnt` counts within LO and HI.
  - IDLE → LO when `mem_mem_r_en` or the registered `w_en` is 1. Clear `cnt`.
  - LO → HI when `cnt`=`WAIT_CYCLES`-1. Clear `cnt`.
  - HI → DONE when `cnt`=`WAIT_CYCLES`-1.
  - DONE → IDLE unconditionally.
- **Ready:** `ready` = (IDLE and no memory op registered) or DONE. It is combinational from the state and the register.
- **Address mapping:**
  - word = (`mem_alu_res` − `BASE_ADDR`)[18:2].
  - `sram_addr` = {word[16:0], half}, where half is 0 in LO and 1 in HI.
  - Subtraction is 32-bit modulo; an underflow wraps with no error.
- **Stores:**
  - `sram_wdata` is `val_rm[15:0]` in LO and `val_rm[31:16]` in HI.
  - `sram_we_n`=0 throughout LO and HI. It is 1 in every other state and for loads.
- **Loads:**
  - Capture `sram_rdata` into `mem_rdata[15:0]` on the last LO cycle and into `[31:16]` on the last HI cycle.
  - `mem_rdata` holds until the next load overwrites it. Stores never modify it.
- **Unused pins:** in IDLE and DONE, drive `sram_addr` and `sram_wdata` to 0.
- **Simultaneous read and write enables:** treat as a store; `mem_mem_r_en` still propagates unchanged.
- **Forwarding:** `mem_dest` and `mem_wb_en` stay stable and valid during the whole stall.

## Timing
- **Reset values:** all outputs 0 except `ready`=1 and `sram_we_n`=1. The FSM is in IDLE and `cnt`=0.
- **Non-memory instruction:** occupies MEM for 1 cycle with `ready`=1.
- **Memory instruction:** occupies MEM for 2·`WAIT_CYCLES`+2 cycles.
  - Cycle 0 is IDLE with `ready`=0.
  - Then `WAIT_CYCLES` cycles of LO and `WAIT_CYCLES` cycles of HI.
  - The DONE cycle has `ready`=1; the next instruction loads at the end of DONE.
- **Load data:** `mem_rdata` is valid from the DONE cycle onward.
- **Back-to-back memory ops:** the second op's cycle 0 immediately follows DONE. There is no extra bubble.
- **Reset mid-access:** FSM returns to IDLE and the register clears on that edge. `sram_we_n`=1 from the following cycle; the partial write is not rolled back.

## Configuration
- **`MEM_STAGE_STATS_EN` defined:**
  - Adds output `stat_stall_cycles` [31:0], counting cycles with `ready`=0.
  - Adds output `stat_mem_ops` [31:0], incrementing on each DONE.
  - Both are cleared by `rst` and wrap modulo 2^32.
- **`MEM_STAGE_STATS_EN` undefined:** both ports and both counters are absent; behaviour is otherwise identical.

## Structure
- **Package `mem_stage_pkg`:**
  - State enum `mem_state_t` (IDLE, LO, HI, DONE).
  - `SRAM_AW`=18 and `SRAM_DW`=16.
  - Struct `exmem_t` bundling the register fields.
- **Sub-module `sram_access_fsm`:** FSM, counter, pin drive and read-data assembly. The top level keeps the EX/MEM register and the stats counters.

## Test plan
- **Store:** `WAIT_CYCLES`=3, store `val_rm`=0xDEADBEEF to 1028 → `sram_addr` 2/`sram_wdata` 0xBEEF for 3 cycles, then addr 3/0xDEAD for 3 cycles, with `sram_we_n`=0 in those 6 cycles. `ready`=0 for exactly 7 cycles.
- **Load:** model SRAM returns 0xBEEF at addr 2 and 0xDEAD at addr 3; load from 1028 → `mem_rdata`=0xDEADBEEF in the DONE cycle. `sram_we_n` stays 1.
- **ALU op under stall:** ALU op with `exe_dest`=5 and `exe_wb_en`=1 arrives while a load is in flight → `mem_dest` holds the load's destination until DONE, then shows 5 one cycle later. No stall is added for the ALU op.
- **Back-to-back loads:** two loads → second access starts immediately after the first DONE. Total `ready`=0 cycles = 14.
- **Reset mid-store:** `rst` asserted during HI → next cycle: IDLE, `ready`=1, `sram_we_n`=1, all `mem_*` = 0.
- **Stats:** with `MEM_STAGE_STATS_EN`, one store plus one ALU op → `stat_stall_cycles`=7, `stat_mem_ops`=1.
